seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_scan_decoder_if.sv | 25 ++
 rtl/seg7_scan_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Bundle of the multiplexed seven-segment bus and the decoded display view.
// The master drives the segment/anode lines (display driver or bench) and
// observes the decoded results; the slave is the scan decoder.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [6:0]              seg7;
    logic [NUM_DIGITS-1:0]   an;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic                    code_err;
    logic [7:0]              err_digit;
    logic                    frame_done;

    modport master (
        output seg7, an,
        input  digits, digit_valid, digit_blank, code_err, err_digit, frame_done
    );

    modport slave (
        input  seg7, an,
        output digits, digit_valid, digit_blank, code_err, err_digit, frame_done
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed seven-segment display: synchronizes the
// active-low segment and anode lines, waits for each digit to dwell stably,
// then decodes the glyph back to a hex value per digit position.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input logic           clk,
    input logic           reset,
    seg7_scan_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    logic [6:0]              seg_meta_q, seg_meta_d, seg_sync_q, seg_sync_d;
    logic [6:0]              seg_prev_q, seg_prev_d;
    logic [NUM_DIGITS-1:0]   an_meta_q, an_meta_d, an_sync_q, an_sync_d;
    logic [NUM_DIGITS-1:0]   an_prev_q, an_prev_d;
    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    code_err_q, code_err_d;
    logic [7:0]              err_digit_q, err_digit_d;
    logic                    frame_done_q, frame_done_d;

    logic                    an_legal;
    logic                    sample_same;
    logic                    capture;
    logic [7:0]              cnt_inc;
    logic [3:0]              glyph_val;
    logic                    glyph_hit;
    logic [NUM_DIGITS-1:0]   seen_next;

    assign an_legal    = $onehot(~an_sync_q);
    assign sample_same = (seg_sync_q == seg_prev_q) && (an_sync_q == an_prev_q);
    assign cnt_inc     = cnt_q + 8'd1;

    // Two-flop synchronizers plus the previous synchronized sample for change detection
    always_comb begin
        seg_meta_d = bus.seg7;
        seg_sync_d = seg_meta_q;
        an_meta_d  = bus.an;
        an_sync_d  = an_meta_q;
        seg_prev_d = seg_sync_q;
        an_prev_d  = an_sync_q;
    end

    // Stability FSM: count identical samples and fire one capture per dwell
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (an_legal) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            SETTLE: begin
                if (!an_legal) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!sample_same) begin
                    cnt_d = 8'd1;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(STABLE_CYCLES)) begin
                        capture = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (!an_legal) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!sample_same) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Inverse hex-to-segment lookup on the synchronized bus (g..a, active-low)
    always_comb begin
        glyph_val = '0;
        glyph_hit = 1'b1;
        case (seg_sync_q)
            7'b1000000: glyph_val = 4'h0;
            7'b1111001: glyph_val = 4'h1;
            7'b0100100: glyph_val = 4'h2;
            7'b0110000: glyph_val = 4'h3;
            7'b0011001: glyph_val = 4'h4;
            7'b0010010: glyph_val = 4'h5;
            7'b0000010: glyph_val = 4'h6;
            7'b1111000: glyph_val = 4'h7;
            7'b0000000: glyph_val = 4'h8;
            7'b0011000: glyph_val = 4'h9;
            7'b0001000: glyph_val = 4'hA;
            7'b0000011: glyph_val = 4'hB;
            7'b1000110: glyph_val = 4'hC;
            7'b0100001: glyph_val = 4'hD;
            7'b0000110: glyph_val = 4'hE;
            7'b0001110: glyph_val = 4'hF;
            default:    glyph_hit = 1'b0;
        endcase
    end

    // Capture update: per-digit value/flags, error pulse and frame tracking
    always_comb begin
        digits_d     = digits_q;
        valid_d      = valid_q;
        blank_d      = blank_q;
        err_digit_d  = err_digit_q;
        code_err_d   = 1'b0;
        frame_done_d = 1'b0;
        seen_d       = seen_q;
        seen_next    = seen_q;
        if (capture) begin
            // an is one-hot-low here, so exactly one iteration matches
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (!an_sync_q[i]) begin
                    seen_next[i] = 1'b1;
                    if (glyph_hit) begin
                        digits_d[4*i +: 4] = glyph_val;
                        valid_d[i]         = 1'b1;
                        blank_d[i]         = 1'b0;
                    end else if (seg_sync_q == 7'h7F) begin
                        valid_d[i] = 1'b0;
                        blank_d[i] = 1'b1;
                    end else begin
                        valid_d[i]  = 1'b0;
                        blank_d[i]  = 1'b0;
                        code_err_d  = 1'b1;
                        err_digit_d = 8'(i);
                    end
                end
            end
            if (&seen_next) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d = seen_next;
            end
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_meta_q   <= '0;
            seg_sync_q   <= '0;
            seg_prev_q   <= '0;
            an_meta_q    <= '0;
            an_sync_q    <= '0;
            an_prev_q    <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            seen_q       <= '0;
            digits_q     <= '0;
            valid_q      <= '0;
            blank_q      <= '0;
            code_err_q   <= 1'b0;
            err_digit_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            seg_meta_q   <= seg_meta_d;
            seg_sync_q   <= seg_sync_d;
            seg_prev_q   <= seg_prev_d;
            an_meta_q    <= an_meta_d;
            an_sync_q    <= an_sync_d;
            an_prev_q    <= an_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            blank_q      <= blank_d;
            code_err_q   <= code_err_d;
            err_digit_q  <= err_digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.digit_blank = blank_q;
    assign bus.code_err    = code_err_q;
    assign bus.err_digit   = err_digit_q;
    assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scans,
// checked against a dwell-length model of the display contents.
module tb_seg7_scan_decoder;
    localparam int N = 4;
    localparam int S = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.NUM_DIGITS(N)) bus_if ();

    seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int tests = 0;
    int fails = 0;

    // Reference glyph table, index = hex value (g..a, active-low)
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model of the display state
    int           exp_dig [N];
    logic [N-1:0] exp_valid, exp_blank, exp_seen;
    int           exp_err_cnt = 0, exp_frame_cnt = 0, exp_err_digit = 0;
    logic [6:0]   prev_s;
    logic [N-1:0] prev_a;
    bit           have_prev = 0;
    int           run = 0;

    // Observed pulses
    int obs_err_cnt = 0, obs_frame_cnt = 0, obs_err_digit = 0;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus_if.code_err === 1'b1) begin
                obs_err_cnt++;
                obs_err_digit = int'(bus_if.err_digit);
            end
            if (bus_if.frame_done === 1'b1) obs_frame_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_legal(input logic [N-1:0] a);
        int z = 0;
        for (int i = 0; i < N; i++) if (!a[i]) z++;
        return z == 1;
    endfunction

    function automatic int digit_of(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (!a[i]) return i;
        return 0;
    endfunction

    function automatic logic [4*N-1:0] exp_vec();
        logic [4*N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(exp_dig[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) exp_dig[i] = 0;
        exp_valid = '0; exp_blank = '0; exp_seen = '0;
        exp_err_digit = 0;
        have_prev = 0; run = 0;
    endtask

    task automatic model_capture(input logic [6:0] s, input int k);
        int v = -1;
        for (int g = 0; g < 16; g++) if (glyph[g] == s) v = g;
        if (v >= 0) begin
            exp_dig[k] = v; exp_valid[k] = 1'b1; exp_blank[k] = 1'b0;
        end else if (s == 7'h7F) begin
            exp_valid[k] = 1'b0; exp_blank[k] = 1'b1;
        end else begin
            exp_valid[k] = 1'b0; exp_blank[k] = 1'b0;
            exp_err_cnt++; exp_err_digit = k;
        end
        exp_seen[k] = 1'b1;
        if (&exp_seen) begin
            exp_frame_cnt++;
            exp_seen = '0;
        end
    endtask

    // Drive a pattern for n clock edges; a legal pattern seen S times in a row is captured once
    task automatic hold(input logic [6:0] s, input logic [N-1:0] a, input int n);
        bus_if.seg7 = s;
        bus_if.an   = a;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (have_prev && s == prev_s && a == prev_a) run++;
            else run = 1;
            prev_s = s; prev_a = a; have_prev = 1;
            if (run == S && is_legal(a)) model_capture(s, digit_of(a));
            #1;
        end
    endtask

    task automatic flush();
        hold(7'h7F, '1, 4);
    endtask

    task automatic do_reset();
        bus_if.an = '1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.seg7 = 7'($urandom);
        bus_if.an   = 4'($urandom);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus_if.digits, bus_if.digit_valid, bus_if.digit_blank, bus_if.code_err,
             bus_if.err_digit, bus_if.frame_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got digits=%h valid=%b blank=%b err=%b err_digit=%0d frame=%b, want all 0",
                     bus_if.digits, bus_if.digit_valid, bus_if.digit_blank, bus_if.code_err,
                     bus_if.err_digit, bus_if.frame_done);
        end
        reset = 1'b0;
        model_reset();
        // partial dwell, then reset: the dwell must restart after release
        hold(7'h78, 4'b0111, 6);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        hold(7'h78, 4'b0111, 9);
        tests++;
        if (bus_if.digit_valid !== 4'b0000 || bus_if.digits !== 16'h0000) begin
            fails++;
            $display("FAIL reset_fresh_dwell_early: got valid=%b digits=%h, want 0000 0000",
                     bus_if.digit_valid, bus_if.digits);
        end
        hold(7'h78, 4'b0111, 1);
        tests++;
        if (bus_if.digit_valid !== 4'b1000 || bus_if.digits !== 16'h7000) begin
            fails++;
            $display("FAIL reset_fresh_dwell_capture: got valid=%b digits=%h, want 1000 7000",
                     bus_if.digit_valid, bus_if.digits);
        end
    endtask

    task automatic test_latency();
        hold(7'h24, 4'b1110, 9);
        tests++;
        if (bus_if.digits[3:0] !== 4'h0 || bus_if.digit_valid !== 4'b1000) begin
            fails++;
            $display("FAIL latency_early: got d0=%h valid=%b, want 0 1000",
                     bus_if.digits[3:0], bus_if.digit_valid);
        end
        hold(7'h24, 4'b1110, 1);
        tests++;
        if (bus_if.digits[3:0] !== 4'h2 || bus_if.digit_valid !== 4'b1001) begin
            fails++;
            $display("FAIL latency_capture: got d0=%h valid=%b, want 2 1001",
                     bus_if.digits[3:0], bus_if.digit_valid);
        end
        flush();
    endtask

    task automatic test_full_frame();
        int f0;
        do_reset();
        f0 = obs_frame_cnt;
        hold(glyph[1], 4'b1110, 20);
        hold(glyph[2], 4'b1101, 20);
        hold(glyph[5], 4'b1011, 20);
        tests++;
        if (obs_frame_cnt !== f0) begin
            fails++;
            $display("FAIL frame_early: got %0d frame pulses before digit 3, want 0", obs_frame_cnt - f0);
        end
        hold(glyph[9], 4'b0111, 20);
        flush();
        tests++;
        if (obs_frame_cnt !== f0 + 1) begin
            fails++;
            $display("FAIL frame_pulse: got %0d frame pulses, want 1", obs_frame_cnt - f0);
        end
        tests++;
        if (bus_if.digits !== 16'h9521 || bus_if.digit_valid !== 4'hF) begin
            fails++;
            $display("FAIL frame_digits: got digits=%h valid=%b, want 9521 1111",
                     bus_if.digits, bus_if.digit_valid);
        end
    endtask

    task automatic test_glitch();
        hold(glyph[3], 4'b1101, 5);
        hold(glyph[6], 4'b1101, 9);
        tests++;
        if (bus_if.digits[7:4] !== 4'h2) begin
            fails++;
            $display("FAIL glitch_no_capture: got d1=%h, want 2", bus_if.digits[7:4]);
        end
        hold(glyph[6], 4'b1101, 1);
        tests++;
        if (bus_if.digits[7:4] !== 4'h6) begin
            fails++;
            $display("FAIL glitch_restart_capture: got d1=%h, want 6", bus_if.digits[7:4]);
        end
        flush();
    endtask

    task automatic test_bad_blank();
        int e0 = obs_err_cnt;
        hold(7'h55, 4'b1011, 20);
        flush();
        tests++;
        if (obs_err_cnt !== e0 + 1 || obs_err_digit !== 2 || bus_if.err_digit !== 8'd2) begin
            fails++;
            $display("FAIL bad_glyph_err: got pulses=%0d pulse_digit=%0d err_digit=%0d, want 1 2 2",
                     obs_err_cnt - e0, obs_err_digit, bus_if.err_digit);
        end
        tests++;
        if (bus_if.digit_valid[2] !== 1'b0 || bus_if.digits[11:8] !== 4'h5) begin
            fails++;
            $display("FAIL bad_glyph_state: got valid2=%b d2=%h, want 0 5",
                     bus_if.digit_valid[2], bus_if.digits[11:8]);
        end
        hold(7'h7F, 4'b1011, 20);
        flush();
        tests++;
        if (bus_if.digit_blank[2] !== 1'b1 || obs_err_cnt !== e0 + 1 || bus_if.err_digit !== 8'd2) begin
            fails++;
            $display("FAIL blank_glyph: got blank2=%b pulses=%0d err_digit=%0d, want 1 1 2",
                     bus_if.digit_blank[2], obs_err_cnt - e0, bus_if.err_digit);
        end
    endtask

    task automatic test_illegal_anode();
        logic [4*N-1:0] d0 = bus_if.digits;
        logic [N-1:0]   v0 = bus_if.digit_valid;
        logic [N-1:0]   b0 = bus_if.digit_blank;
        int e0 = obs_err_cnt;
        int f0 = obs_frame_cnt;
        hold(glyph[8], 4'b1100, 50);
        flush();
        tests++;
        if (bus_if.digits !== d0 || bus_if.digit_valid !== v0 || bus_if.digit_blank !== b0 ||
            obs_err_cnt !== e0 || obs_frame_cnt !== f0) begin
            fails++;
            $display("FAIL illegal_anode_quiet: got digits=%h valid=%b blank=%b, want %h %b %b",
                     bus_if.digits, bus_if.digit_valid, bus_if.digit_blank, d0, v0, b0);
        end
        hold(glyph[10], 4'b1101, 10);
        flush();
        tests++;
        if (bus_if.digits[7:4] !== 4'hA || bus_if.digit_valid[1] !== 1'b1) begin
            fails++;
            $display("FAIL illegal_then_legal: got d1=%h valid1=%b, want A 1",
                     bus_if.digits[7:4], bus_if.digit_valid[1]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 40; p++) begin
                logic [6:0]   s;
                logic [N-1:0] a;
                int sel = int'($urandom_range(0, 99));
                if (sel < 60)      s = glyph[$urandom_range(0, 15)];
                else if (sel < 75) s = 7'h7F;
                else               s = 7'($urandom);
                if ($urandom_range(0, 99) < 85) begin
                    a = '1;
                    a[$urandom_range(0, N-1)] = 1'b0;
                end else begin
                    a = 4'($urandom);
                end
                hold(s, a, int'($urandom_range(1, 20)));
            end
            flush();
            tests++;
            if (bus_if.digits !== exp_vec() || bus_if.digit_valid !== exp_valid ||
                bus_if.digit_blank !== exp_blank) begin
                fails++;
                $display("FAIL random_state[%0d]: got digits=%h valid=%b blank=%b, want %h %b %b",
                         r, bus_if.digits, bus_if.digit_valid, bus_if.digit_blank,
                         exp_vec(), exp_valid, exp_blank);
            end
            tests++;
            if (obs_err_cnt !== exp_err_cnt || bus_if.err_digit !== 8'(exp_err_digit)) begin
                fails++;
                $display("FAIL random_errors[%0d]: got pulses=%0d err_digit=%0d, want %0d %0d",
                         r, obs_err_cnt, bus_if.err_digit, exp_err_cnt, exp_err_digit);
            end
            tests++;
            if (obs_frame_cnt !== exp_frame_cnt) begin
                fails++;
                $display("FAIL random_frames[%0d]: got %0d frame pulses, want %0d",
                         r, obs_frame_cnt, exp_frame_cnt);
            end
        end
    endtask

    initial begin
        bus_if.seg7 = 7'h7F;
        bus_if.an   = '1;
        reset       = 1'b1;
        test_reset();
        test_latency();
        test_full_frame();
        test_glitch();
        test_bad_blank();
        test_illegal_anode();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
